// File: rtl/prbs_pkg.sv
// prbs_pkg: shared checker states and the Galois LFSR recurrence used by generator and checker.
package prbs_pkg;
   typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} state_t;
   localparam int MAX_W = 256;
   // Operates on a MAX_W container; callers zero-extend and truncate to their own width w.
   function automatic logic [MAX_W-1:0] prbs_nxt(input logic [MAX_W-1:0] q, input int w);
      logic [MAX_W-1:0] n;
      n = '0;
      n[0] = q[1];
      for (int i = 1; i < MAX_W - 1; i++)
         if (i < w - 1) n[i] = q[i+1] ^ q[i-1];
      n[w-1] = q[0];
      return n;
   endfunction
endpackage

// File: rtl/dffrc.sv
// dffrc: register with async active-low reset to zero, sync clear and load enable.
module dffrc #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/prbs_chk_fsm.sv
// prbs_chk_fsm: hunt/verify/lock sequencing with match and miss counters.
module prbs_chk_fsm
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int MISS_MAX = 3
) (
   input  logic   clk_i,
   input  logic   rst_n_i,
   input  logic   en_i,
   input  logic   vld_i,
   input  logic   nz_i,
   input  logic   match_i,
   output state_t state_o,
   output logic   lock_o
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int XW = $clog2(MISS_MAX + 1);
   logic [1:0] st_r;
   state_t st_d;
   logic [MW-1:0] mc_q, mc_d;
   logic [XW-1:0] xc_q, xc_d;
   logic mc_full, xc_full;
   dffrc #(.W(2))  u_st (.clk(clk_i), .rst_n(rst_n_i), .clr(1'b0), .en(1'b1), .d(st_d), .q(st_r));
   dffrc #(.W(MW)) u_mc (.clk(clk_i), .rst_n(rst_n_i), .clr(1'b0), .en(1'b1), .d(mc_d), .q(mc_q));
   dffrc #(.W(XW)) u_xc (.clk(clk_i), .rst_n(rst_n_i), .clr(1'b0), .en(1'b1), .d(xc_d), .q(xc_q));
   assign state_o = state_t'(st_r);
   assign lock_o  = state_o == LOCKED;
   assign mc_full = mc_q + MW'(1) == MW'(LOCK_CNT);
   assign xc_full = xc_q + XW'(1) == XW'(MISS_MAX);
   always_comb begin
      st_d = state_o;
      mc_d = mc_q;
      xc_d = xc_q;
      if (!en_i) begin
         st_d = IDLE;
         mc_d = '0;
         xc_d = '0;
      end else if (state_o == IDLE) st_d = HUNT;
      else if (vld_i)
         case (state_o)
            HUNT:
               if (nz_i) begin
                  mc_d = MW'(1);
                  st_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
               end
            VERIFY: begin
               mc_d = match_i ? mc_q + MW'(1) : MW'(1);
               st_d = match_i ? (mc_full ? LOCKED : VERIFY) : (nz_i ? VERIFY : HUNT);
            end
            LOCKED: begin
               xc_d = (match_i || xc_full) ? '0 : xc_q + XW'(1);
               st_d = (!match_i && xc_full) ? HUNT : LOCKED;
            end
            default: st_d = IDLE;
         endcase
   end
endmodule

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker with lock status, error pulse and saturating error count.
module prbs_chk
   import prbs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LOCK_CNT   = 4,
   parameter int MISS_MAX   = 3,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic                  lock_o,
   output logic                  err_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_o
);
   state_t st;
   logic [DATA_WIDTH-1:0] local_q, local_d, exp_w;
   logic nz, match, beat, load, err_d;
   assign exp_w = DATA_WIDTH'(prbs_nxt(MAX_W'(local_q), DATA_WIDTH));
   assign nz    = |dat_i;
   assign match = dat_i == exp_w;
   assign beat  = en_i && vld_i;
   // Once locked the local copy free-runs; received data only seeds it while hunting/verifying.
   assign load    = beat && (st == LOCKED || (st == HUNT && nz) || (st == VERIFY && (match || nz)));
   assign local_d = (st == LOCKED) ? exp_w : dat_i;
   assign err_d   = beat && st == LOCKED && !match;
   prbs_chk_fsm #(.LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) u_fsm (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .vld_i(vld_i),
      .nz_i(nz), .match_i(match), .state_o(st), .lock_o(lock_o)
   );
   dffrc #(.W(DATA_WIDTH)) u_local (.clk(clk_i), .rst_n(rst_n_i), .clr(1'b0), .en(load),
                                    .d(local_d), .q(local_q));
   dffrc #(.W(1)) u_err (.clk(clk_i), .rst_n(rst_n_i), .clr(1'b0), .en(1'b1), .d(err_d), .q(err_o));
   dffrc #(.W(CNT_WIDTH)) u_cnt (.clk(clk_i), .rst_n(rst_n_i), .clr(clr_i), .en(err_d && !(&err_cnt_o)),
                                 .d(err_cnt_o + CNT_WIDTH'(1)), .q(err_cnt_o));
endmodule

// File: doc/prbs_chk.md
Name: prbs_chk

Overview:
Downstream checker for the Galois LFSR pattern generator. Consumes a valid-qualified word stream carrying the generator's output and self-synchronises a local copy of the same recurrence. Reports lock status, per-word mismatch pulses and a saturating error count. Used for link/loopback BIST behind the generator.

Parameters:
DATA_WIDTH, 32, word width; must be at least 3.
LOCK_CNT, 4, consecutive matching words needed to declare lock; must be at least 1.
MISS_MAX, 3, consecutive mismatching words while locked that drop lock; must be at least 1.
CNT_WIDTH, 32, width of the error counter.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
en_i  input  1  checker enable; low forces IDLE
clr_i  input  1  synchronous clear of err_cnt_o
vld_i  input  1  dat_i valid this cycle
dat_i  input  DATA_WIDTH  received generator word
lock_o  output  1  checker locked
err_o  output  1  one-cycle pulse per mismatched word while locked
err_cnt_o  output  CNT_WIDTH  saturating count of mismatched words while locked

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous, active-low (rst_n_i). In reset: state=IDLE, local reg=0, match/miss counters=0, lock_o=0, err_o=0, err_cnt_o=0.
- Recurrence nxt(q): nxt[0]=q[1]; nxt[W-1]=q[0]; nxt[i]=q[i+1]^q[i-1] for 0<i<W-1. This is bit-identical to the generator's recurrence.
- All registered outputs change on the clk_i edge after the qualifying vld_i beat. Latency is 1 cycle. Beats with vld_i=0 are ignored and all state holds.
- IDLE: leave to HUNT when en_i=1.
- HUNT: on a valid beat with dat_i!=0, local<=dat_i, match_cnt<=1, go to VERIFY (or straight to LOCKED if LOCK_CNT==1). An all-zero word is ignored (zero is the LFSR lock-up state).
- VERIFY: on a valid beat, compare dat_i with nxt(local).
  - Match: local<=dat_i, match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED and set lock_o=1.
  - Mismatch: reseed. If dat_i!=0: local<=dat_i, match_cnt<=1. If dat_i==0: go to HUNT.
- LOCKED: local<=nxt(local) on every valid beat (flywheel; received data never reloads local).
  - Match: miss_cnt<=0.
  - Mismatch: err_o=1 for exactly one cycle; err_cnt_o++ (saturates at all-ones, no wrap); miss_cnt++.
  - When miss_cnt reaches MISS_MAX: go to HUNT, lock_o<=0, miss_cnt<=0. The MISS_MAX-th mismatch itself still pulses err_o and counts.
- en_i=0 in any state: next cycle state=IDLE, lock_o=0, match/miss counters=0. err_cnt_o is retained. en_i has priority over a simultaneous vld_i beat.
- clr_i=1: err_cnt_o<=0 next cycle. If it coincides with a counted mismatch, the result is 0 (clear wins). Lock state is unaffected.
- err_o only ever asserts in LOCKED. Mismatches in VERIFY are not counted.
- Asynchronous reset mid-stream returns everything to reset values immediately. The checker re-hunts once reset is released and en_i=1.

Decomposition:
- Package prbs_pkg: state enum (IDLE, HUNT, VERIFY, LOCKED); a function computing nxt(q) parameterised on DATA_WIDTH. The generator should share this function.
- Registers are built from the codebase's dffrc cells.
- One sub-module, prbs_chk_fsm: state, match/miss counters, lock_o. The datapath (local reg, comparator, error counter) stays in the top.

Test Plan:
- DATA_WIDTH=8, LOCK_CNT=3. Feed 8'h01, 8'h82, 8'h45 on consecutive cycles -> lock_o rises the cycle after 8'h45; err_o never asserts.
- Locked at 8'h45, next beat sends 8'h00 instead of its expected successor -> err_o pulses 1 cycle, err_cnt_o=1, lock_o stays 1. The following correct word gives no error.
- MISS_MAX=3 while locked: 3 consecutive wrong words -> err_cnt_o increments 1,2,3; lock_o falls after the 3rd; state HUNT.
- HUNT with stream 8'h00, 8'h00, 8'h01, 8'h82, 8'h45 -> zeros ignored; lock after 8'h45.
- CNT_WIDTH=4, err_cnt_o=4'hF, another locked mismatch -> stays 4'hF. clr_i pulsed on the same cycle as a mismatch -> 0.
- Locked, then en_i=0 for 1 cycle -> lock_o=0 and err_cnt_o retained. Async rst_n_i low mid-stream -> all outputs 0 immediately.
